// File: rtl/mac_feeder.sv
// mac_feeder
//   Feeds the MAC kernel input port from a raster stream of N-channel pixels.
//   1x1 mode: each accepted pixel is issued as one tap with weight tap 0.
//   3x3 mode: two line buffers plus a 3x3 window register build a valid
//   (unpadded) window for every pixel with row>=2 and col>=2; the window is
//   then issued as 9 consecutive taps, stalling the pixel input meanwhile.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   start, cfg_conv3x3   frame start pulse (IDLE only) and mode to latch
//   wgt_we/addr/data     weight tap write (IDLE only, addr 0..8)
//   pix_vld/rdy/data     input pixel handshake; lane i = bits [i*WI+:WI]
//   is_conv3x3           mode latched at the last accepted start
//   vld_o/din_o/win_o    tap valid, data tap, weight tap to the kernel
//   tap_o                tap index 0..8 (always 0 in 1x1 mode)
//   busy, done           frame in progress / 1-cycle end-of-frame pulse
module mac_feeder #(
    parameter int WI    = 8,
    parameter int N     = 16,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic            cfg_conv3x3,
    input  logic            wgt_we,
    input  logic [3:0]      wgt_addr,
    input  logic [N*WI-1:0] wgt_data,
    input  logic            pix_vld,
    output logic            pix_rdy,
    input  logic [N*WI-1:0] pix_data,
    output logic            is_conv3x3,
    output logic            vld_o,
    output logic [N*WI-1:0] din_o,
    output logic [N*WI-1:0] win_o,
    output logic [3:0]      tap_o,
    output logic            busy,
    output logic            done
);

    localparam int DW = N * WI;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EMIT,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          last_px;

    logic [DW-1:0] wgt [0:8];
    logic [DW-1:0] lb0 [0:IMG_W-1];   // row r-1
    logic [DW-1:0] lb1 [0:IMG_W-1];   // row r-2
    // Window stored row-major: index ky*3+kx, ky=0 oldest row, kx=0 leftmost.
    logic [DW-1:0] win [0:8];

    logic hs;
    logic at_last_col;
    logic at_last_row;
    logic at_last_px;
    logic emit_go;

    always_comb begin
        hs          = pix_vld & pix_rdy;
        at_last_col = (col == CW'(IMG_W - 1));
        at_last_row = (row == RW'(IMG_H - 1));
        at_last_px  = at_last_col & at_last_row;
        emit_go     = (row >= RW'(2)) & (col >= CW'(2));
    end

    // Line buffers and window carry no reset; their contents are don't-care
    // until overwritten by the current frame.
    always_ff @(posedge clk) begin
        if (hs && is_conv3x3) begin
            win[0]   <= win[1];
            win[1]   <= win[2];
            win[2]   <= lb1[col];
            win[3]   <= win[4];
            win[4]   <= win[5];
            win[5]   <= lb0[col];
            win[6]   <= win[7];
            win[7]   <= win[8];
            win[8]   <= pix_data;
            lb1[col] <= lb0[col];
            lb0[col] <= pix_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            last_px    <= 1'b0;
            pix_rdy    <= 1'b0;
            is_conv3x3 <= 1'b0;
            vld_o      <= 1'b0;
            din_o      <= '0;
            win_o      <= '0;
            tap_o      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            for (int unsigned i = 0; i < 9; i++) begin
                wgt[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    vld_o <= 1'b0;
                    done  <= 1'b0;
                    if (wgt_we && (wgt_addr <= 4'd8)) begin
                        wgt[wgt_addr] <= wgt_data;
                    end
                    if (start) begin
                        is_conv3x3 <= cfg_conv3x3;
                        col        <= '0;
                        row        <= '0;
                        state      <= RUN;
                        pix_rdy    <= 1'b1;
                        busy       <= 1'b1;
                    end
                end

                RUN: begin
                    vld_o <= 1'b0;
                    if (hs) begin
                        last_px <= at_last_px;
                        if (at_last_col) begin
                            col <= '0;
                            row <= at_last_row ? '0 : row + RW'(1);
                        end else begin
                            col <= col + CW'(1);
                        end

                        if (!is_conv3x3) begin
                            vld_o <= 1'b1;
                            din_o <= pix_data;
                            win_o <= wgt[0];
                            tap_o <= '0;
                            if (at_last_px) begin
                                state   <= DONE;
                                pix_rdy <= 1'b0;
                                done    <= 1'b1;
                            end
                        end else if (emit_go) begin
                            // Tap 0 is issued from this edge; after the shift
                            // the new win[0] is the current win[1].
                            state   <= EMIT;
                            pix_rdy <= 1'b0;
                            vld_o   <= 1'b1;
                            tap_o   <= '0;
                            din_o   <= win[1];
                            win_o   <= wgt[0];
                        end
                    end
                end

                EMIT: begin
                    if (tap_o == 4'd8) begin
                        vld_o <= 1'b0;
                        if (last_px) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= RUN;
                            pix_rdy <= 1'b1;
                        end
                    end else begin
                        vld_o <= 1'b1;
                        tap_o <= tap_o + 4'd1;
                        din_o <= win[tap_o + 4'd1];
                        win_o <= wgt[tap_o + 4'd1];
                    end
                end

                DONE: begin
                    vld_o   <= 1'b0;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    pix_rdy <= 1'b0;
                    state   <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_feeder.sv
// tb_mac_feeder
//   Frame-level vectors (mode, pixel gaps, control disturbances, expected tap
//   and stall counts) applied in a loop; the expected tap sequence is built
//   from raster coordinates. Reset behaviour is checked by hand-written steps.
module tb_mac_feeder;

    localparam int WI    = 8;
    localparam int N     = 16;
    localparam int IMG_W = 8;
    localparam int IMG_H = 8;
    localparam int DW    = N * WI;
    localparam int NPIX  = IMG_W * IMG_H;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic          cfg_conv3x3;
    logic          wgt_we;
    logic [3:0]    wgt_addr;
    logic [DW-1:0] wgt_data;
    logic          pix_vld;
    logic          pix_rdy;
    logic [DW-1:0] pix_data;
    logic          is_conv3x3;
    logic          vld_o;
    logic [DW-1:0] din_o;
    logic [DW-1:0] win_o;
    logic [3:0]    tap_o;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    mac_feeder #(
        .WI   (WI),
        .N    (N),
        .IMG_W(IMG_W),
        .IMG_H(IMG_H)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .cfg_conv3x3(cfg_conv3x3),
        .wgt_we     (wgt_we),
        .wgt_addr   (wgt_addr),
        .wgt_data   (wgt_data),
        .pix_vld    (pix_vld),
        .pix_rdy    (pix_rdy),
        .pix_data   (pix_data),
        .is_conv3x3 (is_conv3x3),
        .vld_o      (vld_o),
        .din_o      (din_o),
        .win_o      (win_o),
        .tap_o      (tap_o),
        .busy       (busy),
        .done       (done)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Observed taps and event counters, written only by the monitor.
    logic [DW-1:0] q_din[$];
    logic [DW-1:0] q_win[$];
    logic [3:0]    q_tap[$];
    int done_cnt = 0;
    int runs     = 0;
    int run_bad  = 0;
    int low_run  = 0;

    always @(negedge clk) begin
        if (vld_o) begin
            q_din.push_back(din_o);
            q_win.push_back(win_o);
            q_tap.push_back(tap_o);
        end
        if (done) done_cnt++;
        if (busy && !pix_rdy) begin
            low_run++;
        end else begin
            if (busy && pix_rdy && low_run > 0) begin
                runs++;
                if (low_run != 9) run_bad++;
            end
            low_run = 0;
        end
    end

    function automatic logic [DW-1:0] pix(input int r, input int c);
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*WI+:WI] = WI'((r * IMG_W + c + 3 * i) & 255);
        return v;
    endfunction

    function automatic logic [DW-1:0] wv(input logic conv, input int k);
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*WI+:WI] = conv ? WI'((k + 16 * i) & 255) : WI'(1);
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string p);
        chk_int({p, " pix_rdy"}, int'(pix_rdy), 0);
        chk_int({p, " vld_o"}, int'(vld_o), 0);
        chk({p, " din_o"}, din_o, '0);
        chk({p, " win_o"}, win_o, '0);
        chk_int({p, " tap_o"}, int'(tap_o), 0);
        chk_int({p, " is_conv3x3"}, int'(is_conv3x3), 0);
        chk_int({p, " busy"}, int'(busy), 0);
        chk_int({p, " done"}, int'(done), 0);
    endtask

    task automatic wr_wgt(input logic [3:0] a, input logic [DW-1:0] d);
        wgt_we   = 1'b1;
        wgt_addr = a;
        wgt_data = d;
        @(posedge clk); #1;
        wgt_we   = 1'b0;
    endtask

    typedef struct {
        string name;
        logic  conv;
        logic  gaps;
        logic  inject;
        logic  badwr;
        logic  abort;
        int    exp_taps;
        int    exp_runs;
    } vec_t;

    task automatic run_frame(input vec_t v);
        int   base_q, base_done, base_runs, base_bad, idx, cyc, f0, n_exp;
        logic will, injected;
        logic [DW-1:0] e_din[$];
        logic [DW-1:0] e_win[$];
        logic [3:0]    e_tap[$];

        for (int k = 0; k < 9; k++) wr_wgt(4'(k), wv(v.conv, k));
        if (v.badwr) wr_wgt(4'd9, '1);

        base_q    = q_din.size();
        base_done = done_cnt;
        base_runs = runs;
        base_bad  = run_bad;

        start       = 1'b1;
        cfg_conv3x3 = v.conv;
        @(posedge clk); #1;
        start       = 1'b0;

        idx = 0; cyc = 0; will = 1'b0; injected = 1'b0;
        while (idx < NPIX && cyc < 3000) begin
            if (v.abort && idx == 32) break;
            pix_vld  = v.gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_data = pix(idx / IMG_W, idx % IMG_W);
            if (v.inject && !injected && idx == 20) begin
                injected    = 1'b1;
                start       = 1'b1;
                cfg_conv3x3 = ~v.conv;
                wgt_we      = 1'b1;
                wgt_addr    = 4'd0;
                wgt_data    = '1;
            end
            will = pix_vld && pix_rdy;
            @(posedge clk); #1;
            start       = 1'b0;
            wgt_we      = 1'b0;
            cfg_conv3x3 = v.conv;
            if (will) idx++;
            cyc++;
        end
        pix_vld = 1'b0;

        if (v.abort) begin
            rstn = 1'b0;
            #2;
            chk_zero({v.name, " in_reset"});
            @(posedge clk); #1;
            rstn = 1'b1;
            @(posedge clk); #1;
            chk_zero({v.name, " after_reset"});
            return;
        end

        chk_int({v.name, " pixels_taken"}, idx, NPIX);
        cyc = 0;
        while (done_cnt == base_done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        repeat (2) @(posedge clk);
        #1;

        chk_int({v.name, " done_pulses"}, done_cnt - base_done, 1);
        chk_int({v.name, " busy_after"}, int'(busy), 0);
        chk_int({v.name, " is_conv3x3"}, int'(is_conv3x3), int'(v.conv));
        chk_int({v.name, " tap_count"}, q_din.size() - base_q, v.exp_taps);
        chk_int({v.name, " stall_runs"}, runs - base_runs, v.exp_runs);
        chk_int({v.name, " stall_len_bad"}, run_bad - base_bad, 0);

        if (v.conv) begin
            for (int r = 2; r < IMG_H; r++)
                for (int c = 2; c < IMG_W; c++)
                    for (int k = 0; k < 9; k++) begin
                        e_din.push_back(pix(r - 2 + k / 3, c - 2 + k % 3));
                        e_win.push_back(wv(1'b1, k));
                        e_tap.push_back(4'(k));
                    end
        end else begin
            for (int p = 0; p < NPIX; p++) begin
                e_din.push_back(pix(p / IMG_W, p % IMG_W));
                e_win.push_back(wv(1'b0, 0));
                e_tap.push_back(4'd0);
            end
        end

        n_exp = e_din.size();
        for (int i = 0; i < n_exp; i++) begin
            if (base_q + i >= q_din.size()) break;
            f0 = n_fail;
            chk($sformatf("%s din[%0d]", v.name, i), q_din[base_q+i], e_din[i]);
            chk($sformatf("%s win[%0d]", v.name, i), q_win[base_q+i], e_win[i]);
            chk_int($sformatf("%s tap[%0d]", v.name, i), int'(q_tap[base_q+i]), int'(e_tap[i]));
            if (n_fail != f0) break;
        end
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{"t1_1x1",       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NPIX, 0};
        tbl[1] = '{"t2_3x3",       1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 324,  35};
        tbl[2] = '{"t4_1x1_gaps",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, NPIX, 0};
        tbl[3] = '{"t4_3x3_gaps",  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 324,  35};
        tbl[4] = '{"t5_busy_ctl",  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 324,  35};
        tbl[5] = '{"t5_bad_addr",  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 324,  35};
        tbl[6] = '{"t6_abort",     1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0,    0};
        tbl[7] = '{"t6_rerun",     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 324,  35};

        rstn        = 1'b0;
        start       = 1'b0;
        cfg_conv3x3 = 1'b0;
        wgt_we      = 1'b0;
        wgt_addr    = '0;
        wgt_data    = '0;
        pix_vld     = 1'b0;
        pix_data    = '0;

        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rstn = 1'b1;
        @(posedge clk); #1;
        chk_zero("idle");

        for (int t = 0; t < 8; t++) run_frame(tbl[t]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
